nvram_backup_ctrl: RTL
======================

Name: nvram_backup_ctrl

Overview:
- Sequences backup-RAM (cartridge NVRAM) transfers between the 32 KB nvram dual-port buffer and the HPS SD sector interface.
- Sits downstream of the system NVRAM write strobe and upstream of hps_io's sd_lba/sd_rd/sd_wr/sd_ack handshake.
- Handles manual load/save, automatic load after cart download, and OSD-triggered autosave.
- Its bk_loading output holds the core in reset while a load is in progress.

Parameters:
SECTORS_LOG2, 6, log2 of sectors per image (64 x 512 B = 32 KB)
LBA_W, 32, width of sd_lba

Ports:
clk_sys  in  1  system clock
reset  in  1  sync active-high; must NOT include bk_loading
cart_download  in  1  cart ROM download active
img_mounted  in  1  save image mount pulse
img_readonly  in  1  mounted image is read-only
img_size  in  64  mounted image size in bytes
osd_status  in  1  OSD open
load_req  in  1  manual load level (menu)
save_req  in  1  manual save level (menu)
autosave_en  in  1  autosave option
nvram_we  in  1  core write strobe into NVRAM
sd_ack  in  1  HPS sector-transfer acknowledge
sd_lba  out  LBA_W  sector number; low SECTORS_LOG2 bits index the NVRAM buffer
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
bk_ena  out  1  backup RAM valid for the current cart
bk_loading  out  1  load in progress
bk_state  out  1  transfer busy
bk_pending  out  1  unsaved NVRAM writes exist

Behaviour:
- Reset: all outputs 0; FSM to IDLE; edge-detect registers cleared.
- Outputs are registered. Every condition below takes effect on the next clk_sys edge.
- bk_ena:
  - Cleared on the rising edge of cart_download.
  - Set in any cycle with cart_download & img_mounted & ~img_readonly.
  - Set wins if both occur in the same cycle.
- Triggers are rising-edge detected on the gated signals; each is acted on only in IDLE:
  - L = load_req & bk_ena.
  - S = (save_req | (bk_pending & osd_status & autosave_en)) & bk_ena.
  - A = falling edge of cart_download & (img_size != 0) & bk_ena. Acts as a load.
- Priority when triggers coincide: A or L over S. A trigger arriving while busy is dropped, not queued.
- On trigger:
  - bk_state = 1; sd_lba = 0; bk_loading = 1 for a load, 0 for a save.
  - sd_rd = load; sd_wr = ~load. Go to XFER.
- XFER:
  - On the rising edge of sd_ack, clear sd_rd and sd_wr (next cycle).
  - On the falling edge of sd_ack:
    - If sd_lba[SECTORS_LOG2-1:0] is all ones: bk_state = 0, bk_loading = 0, go to IDLE.
    - Otherwise: sd_lba += 1 and re-assert sd_rd/sd_wr for the same direction.
- Request signals stay asserted until sd_ack rises, with no timeout.
- sd_ack glitch rules:
  - An ack rise with no request pending is ignored.
  - An ack fall outside XFER is ignored.
- bk_pending:
  - Set when bk_ena & ~osd_status & nvram_we.
  - Otherwise cleared whenever bk_state = 1.
  - Set has priority, so a core write during a save leaves it at 1.
- sd_lba upper bits (above SECTORS_LOG2) are always 0.
- reset mid-transfer: immediate return to IDLE with outputs 0. The HPS may still complete the outstanding ack, and that ack is ignored.

Test Plan:
- Download with a writable 32768-byte image mounted, then cart_download falls -> bk_ena = 1; auto-load runs; sd_rd pulses 64 times with sd_lba 0..63; bk_loading and bk_state stay high until 1 cycle after the 64th ack falls, then both are 0.
- bk_ena = 1, save_req rises; ack model with 3-cycle delay and 5-cycle width -> sd_wr = 1 with sd_lba = 0; sd_wr drops 1 cycle after ack rises; bk_loading = 0 throughout; 64 sectors total; sd_rd never asserts.
- nvram_we pulse with osd_status = 0 -> bk_pending = 1; then osd_status = 1 and autosave_en = 1 -> a save starts and bk_pending = 0 on the cycle after bk_state rises. Repeat with autosave_en = 0 -> no transfer and bk_pending stays 1.
- Mount with img_readonly = 1 during download -> bk_ena = 0; load_req and save_req edges produce no sd_rd/sd_wr; cart_download falling with img_size = 32768 produces no load.
- load_req and save_req rise in the same cycle -> a load runs (sd_rd); save_req toggled mid-load is ignored and no save follows.
- reset asserted after the 10th ack falls (sd_lba = 10) -> the next cycle has sd_rd = sd_wr = 0, sd_lba = 0 and bk_state = bk_loading = bk_pending = bk_ena = 0; a stray ack fall afterwards changes nothing.

Source files
------------

// File: rtl/nvram_backup_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nvram_backup_ctrl_if
// Brief    : HPS SD sector handshake between the backup controller and hps_io.
// Revision : 1.0 - initial release
// ============================================================================
interface nvram_backup_ctrl_if #(
    parameter int LBA_W = 32
);
    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack
    );
endinterface
`default_nettype wire

// File: rtl/nvram_backup_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nvram_backup_ctrl
// Brief    : Sequences cartridge NVRAM load/save between the 32 KB buffer and
//            the HPS SD sector interface (manual, auto-load, OSD autosave).
// Revision : 1.0 - initial release
// ============================================================================
module nvram_backup_ctrl #(
    parameter int SECTORS_LOG2 = 6,
    parameter int LBA_W        = 32
) (
    input  wire logic        clk_sys,
    input  wire logic        reset,
    input  wire logic        cart_download,
    input  wire logic        img_mounted,
    input  wire logic        img_readonly,
    input  wire logic [63:0] img_size,
    input  wire logic        osd_status,
    input  wire logic        load_req,
    input  wire logic        save_req,
    input  wire logic        autosave_en,
    input  wire logic        nvram_we,
    nvram_backup_ctrl_if.master sd,
    output logic             bk_ena,
    output logic             bk_loading,
    output logic             bk_state,
    output logic             bk_pending
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_XFER = 1'b1;

    logic [0:0]              r_state;
    logic [SECTORS_LOG2-1:0] r_lba;
    logic                    r_rd;
    logic                    r_wr;
    logic                    r_bk_ena;
    logic                    r_loading;
    logic                    r_busy;
    logic                    r_pending;
    logic                    r_dl_d;
    logic                    r_l_d;
    logic                    r_s_d;
    logic                    r_ack_d;

    logic w_l;
    logic w_s;
    logic w_dl_rise;
    logic w_dl_fall;
    logic w_load_trig;
    logic w_save_trig;
    logic w_ack_rise;
    logic w_ack_fall;

    // Triggers are gated by bk_ena before edge detection, so enabling a level
    // that is already high also counts as an edge.
    assign w_l         = load_req & r_bk_ena;
    assign w_s         = (save_req | (r_pending & osd_status & autosave_en)) & r_bk_ena;
    assign w_dl_rise   = cart_download & ~r_dl_d;
    assign w_dl_fall   = ~cart_download & r_dl_d;
    assign w_load_trig = (w_l & ~r_l_d) | (w_dl_fall & (img_size != 64'd0) & r_bk_ena);
    assign w_save_trig = w_s & ~r_s_d;
    assign w_ack_rise  = sd.sd_ack & ~r_ack_d;
    assign w_ack_fall  = ~sd.sd_ack & r_ack_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_lba     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_bk_ena  <= 1'b0;
            r_loading <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_dl_d    <= 1'b0;
            r_l_d     <= 1'b0;
            r_s_d     <= 1'b0;
            r_ack_d   <= 1'b0;
        end else begin
            r_dl_d  <= cart_download;
            r_l_d   <= w_l;
            r_s_d   <= w_s;
            r_ack_d <= sd.sd_ack;

            // A mount seen in the same cycle as the download start still enables.
            if (w_dl_rise) begin
                r_bk_ena <= 1'b0;
            end
            if (cart_download & img_mounted & ~img_readonly) begin
                r_bk_ena <= 1'b1;
            end

            if (r_bk_ena & ~osd_status & nvram_we) begin
                r_pending <= 1'b1;
            end else if (r_busy) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (w_load_trig | w_save_trig) begin
                        r_state   <= c_S_XFER;
                        r_busy    <= 1'b1;
                        r_lba     <= '0;
                        r_loading <= w_load_trig;
                        r_rd      <= w_load_trig;
                        r_wr      <= ~w_load_trig;
                    end
                end
                c_S_XFER: begin
                    if (w_ack_rise & (r_rd | r_wr)) begin
                        r_rd <= 1'b0;
                        r_wr <= 1'b0;
                    end else if (w_ack_fall) begin
                        if (&r_lba) begin
                            r_state   <= c_S_IDLE;
                            r_busy    <= 1'b0;
                            r_loading <= 1'b0;
                        end else begin
                            r_lba <= r_lba + SECTORS_LOG2'(1);
                            r_rd  <= r_loading;
                            r_wr  <= ~r_loading;
                        end
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign sd.sd_lba  = {{(LBA_W-SECTORS_LOG2){1'b0}}, r_lba};
    assign sd.sd_rd   = r_rd;
    assign sd.sd_wr   = r_wr;
    assign bk_ena     = r_bk_ena;
    assign bk_loading = r_loading;
    assign bk_state   = r_busy;
    assign bk_pending = r_pending;

endmodule
`default_nettype wire
